// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared pipeline-control types and defaults
package riscv_ctrl_pkg;
   typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} hz_state_t;
   localparam int FLUSH_CYCLES_DEF = 1;
endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: flags an ID source register produced by a load in EX (x0 never hazards)
module load_use_detector (
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_memory_read,
   output logic       load_use
);
   assign load_use = ex_memory_read && ex_rd != 5'd0 &&
                     (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stalls, data-memory freeze and branch-flush sequencing
// Optional HAZARD_PERF_CNT_EN adds the saturating stall_cycles counter.
module hazard_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memory_read,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             hazard_mux_enable,
`ifdef HAZARD_PERF_CNT_EN
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_cycles
`else
   output logic             pipe_hold
`endif
);
   hz_state_t state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic       load_use, wait_mem, flushing;

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3 || CNT_W < 1) begin : g_bad_param
      $error("hazard_controller: illegal FLUSH_CYCLES or CNT_W");
   end

   load_use_detector u_lud (
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_uses_rs2    (id_uses_rs2),
      .ex_rd          (ex_rd),
      .ex_memory_read (ex_memory_read),
      .load_use       (load_use)
   );

   // A nonzero counter marks an interrupted flush, so MEM_WAIT knows where to resume.
   assign wait_mem = state == MEM_WAIT ? !mem_ready : mem_req && !mem_ready;
   assign flushing = state == FLUSH || (state == MEM_WAIT && cnt != 2'd0);

   always_comb begin
      state_nxt         = RUN;
      cnt_nxt           = cnt;
      pc_write          = 1'b1;
      ifid_write        = 1'b1;
      ifid_flush        = 1'b0;
      hazard_mux_enable = 1'b0;
      pipe_hold         = 1'b0;
      if (reset) begin
         pc_write          = 1'b0;
         ifid_write        = 1'b0;
         ifid_flush        = 1'b1;
         hazard_mux_enable = 1'b1;
         cnt_nxt           = 2'd0;
      end else if (wait_mem) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_hold  = 1'b1;
         state_nxt  = MEM_WAIT;
      end else if (flushing) begin
         ifid_flush = 1'b1;
         cnt_nxt    = cnt - 2'd1;
         state_nxt  = cnt == 2'd1 ? RUN : FLUSH;
      end else if (ex_branch_taken) begin
         ifid_flush        = 1'b1;
         hazard_mux_enable = 1'b1;
         cnt_nxt           = 2'(FLUSH_CYCLES);
         state_nxt         = FLUSH;
      end else if (load_use) begin
         pc_write          = 1'b0;
         ifid_write        = 1'b0;
         hazard_mux_enable = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) stall_cycles <= '0;
      else if (!pc_write && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
   end
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vector table plus randomized run against a slot-counting model
module tb_hazard_controller;
   logic clk = 1'b0;
   logic reset, id_uses_rs2, ex_memory_read, ex_branch_taken, mem_req, mem_ready;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic pc_write, ifid_write, ifid_flush, hazard_mux_enable, pipe_hold;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   always #5 clk = ~clk;

   hazard_controller #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
      .clk               (clk),
      .reset             (reset),
      .id_rs1            (id_rs1),
      .id_rs2            (id_rs2),
      .id_uses_rs2       (id_uses_rs2),
      .ex_rd             (ex_rd),
      .ex_memory_read    (ex_memory_read),
      .ex_branch_taken   (ex_branch_taken),
      .mem_req           (mem_req),
      .mem_ready         (mem_ready),
      .pc_write          (pc_write),
      .ifid_write        (ifid_write),
      .ifid_flush        (ifid_flush),
      .hazard_mux_enable (hazard_mux_enable),
`ifdef HAZARD_PERF_CNT_EN
      .pipe_hold         (pipe_hold),
      .stall_cycles      (stall_cycles)
`else
      .pipe_hold         (pipe_hold)
`endif
   );

   // output word: {pc_write, ifid_write, ifid_flush, hazard_mux_enable, pipe_hold}
   localparam logic [4:0] RST = 5'b00110, NRM = 5'b11000, LU = 5'b00010,
                          BR  = 5'b11110, FL  = 5'b11100, HLD = 5'b00001;

   typedef struct {
      logic       r;
      logic [4:0] rs1, rs2;
      logic       u2;
      logic [4:0] rd;
      logic       mr, br, rq, rdy;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs [$];
   int checks = 0, passes = 0;
   int m_left = 0;
   bit m_wait = 1'b0;
   logic [31:0] m_stall = '0;
   logic [31:0] stall_mark = '0;

   function automatic vec_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic u2, logic [4:0] rd,
                               logic mr, logic br, logic rq, logic rdy, logic [4:0] exp);
      vec_t x;
      x.r = r; x.rs1 = rs1; x.rs2 = rs2; x.u2 = u2; x.rd = rd;
      x.mr = mr; x.br = br; x.rq = rq; x.rdy = rdy; x.exp = exp;
      return x;
   endfunction

   // Model: count remaining flush slots and whether memory is outstanding.
   function automatic logic [4:0] model_step(vec_t x);
      bit lu;
      lu = x.mr && x.rd != 0 && (x.rd == x.rs1 || (x.u2 && x.rd == x.rs2));
      if (x.r) begin
         m_left = 0;
         m_wait = 1'b0;
         return RST;
      end
      if (m_wait ? !x.rdy : (x.rq && !x.rdy)) begin
         m_wait = 1'b1;
         return HLD;
      end
      m_wait = 1'b0;
      if (m_left > 0) begin
         m_left--;
         return FL;
      end
      if (x.br) begin
         m_left = 2;
         return BR;
      end
      return lu ? LU : NRM;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
   endtask

   task automatic apply(input vec_t x, output logic [4:0] act, output logic [4:0] mexp);
      @(negedge clk);
      reset = x.r; id_rs1 = x.rs1; id_rs2 = x.rs2; id_uses_rs2 = x.u2; ex_rd = x.rd;
      ex_memory_read = x.mr; ex_branch_taken = x.br; mem_req = x.rq; mem_ready = x.rdy;
      #1;
      act  = {pc_write, ifid_write, ifid_flush, hazard_mux_enable, pipe_hold};
      mexp = model_step(x);
`ifdef HAZARD_PERF_CNT_EN
      check("stall_cycles", stall_cycles, m_stall);
`endif
      if (!x.r && !mexp[4] && m_stall != '1) m_stall++;
   endtask

   initial begin
      logic [4:0] act, mexp;
      vec_t x;
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RST));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RST));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM));
      vecs.push_back(mk(0, 1, 5, 1, 5, 1, 0, 0, 0, LU));   // load-use via rs2
      vecs.push_back(mk(0, 1, 5, 1, 5, 0, 0, 0, 0, NRM));  // bubble now in EX
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, NRM));  // x0 never hazards
      vecs.push_back(mk(0, 3, 0, 0, 3, 1, 0, 0, 0, LU));
      vecs.push_back(mk(0, 1, 4, 0, 4, 1, 0, 0, 0, NRM));  // rs2 not read
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, BR));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FL));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FL));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM));
      vecs.push_back(mk(0, 5, 0, 0, 5, 1, 1, 0, 0, BR));   // branch beats load-use
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FL));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FL));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, HLD));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, NRM));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, BR));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FL));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, HLD));  // wait in flush cycle 2
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, HLD));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, FL));   // one flush slot left
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, HLD));  // branch pending behind wait
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, BR));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, FL));   // branch ignored in FLUSH
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RST));  // reset mid-flush
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM));

      foreach (vecs[i]) begin
         apply(vecs[i], act, mexp);
         check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
`ifdef HAZARD_PERF_CNT_EN
         if (i == 16) stall_mark = stall_cycles;
         if (i == 20) check("stall_mem_wait", stall_cycles, stall_mark + 32'd4);
`endif
      end

      for (int n = 0; n < 600; n++) begin
         x = mk($urandom_range(0, 39) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, 1'($urandom), 5'd0);
         apply(x, act, mexp);
         check($sformatf("rand%0d", n), 32'(act), 32'(mexp));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
